mem_access_unit: RTL and testbench

Memory-stage block of the five-stage RV32I pipeline. It takes the EX/MEM pipeline contents (ALU result, store data, and the load/store control produced by `control_unit`) and runs a single-outstanding request/acknowledge transaction on the data-memory bus. It performs byte-lane alignment for stores and extraction plus sign/zero extension for loads. It registers the result into the MEM/WB stage, which drives the register file write port (`wb_wr_en`/`wb_wr_addr`/`wb_wr_data`).

---
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage of the RV32I pipeline: single-outstanding data-bus transaction with
// store lane steering, load extraction/extension, and the registered MEM/WB write port.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic        wb_reg_file,
   input  logic [4:0]  rd,
   output logic        mem_stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        wb_wr_en,
   output logic [4:0]  wb_wr_addr,
   output logic [31:0] wb_wr_data,
   output logic        misalign_err
);

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

   localparam logic [1:0] ST_B = 2'b00;
   localparam logic [1:0] ST_H = 2'b01;
   localparam logic [1:0] ST_W = 2'b10;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;
   logic        is_mem;
   logic        is_load;
   logic        is_store;
   logic [2:0]  load_type;
   logic [1:0]  store_type;
   logic [1:0]  off;
   logic        misaligned;
   logic [3:0]  acc_be;
   logic [31:0] acc_wdata;

   logic [2:0]  lat_load_type;
   logic [1:0]  lat_off;
   logic [4:0]  lat_rd;
   logic        lat_wb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_result;

   // A simultaneous read+write is treated as a load; unknown type codes fall back to word.
   always_comb begin
      is_mem     = mem_valid & (mem_read | mem_write);
      is_load    = mem_read;
      is_store   = mem_write & ~mem_read;
      off        = alu_result[1:0];
      load_type  = (mem_load_type > LD_HU) ? LD_W : mem_load_type;
      store_type = (mem_store_type == 2'b11) ? ST_W : mem_store_type;
      misaligned = 1'b0;
      acc_be     = 4'b1111;
      acc_wdata  = 32'h0;
      if (is_load) begin
         case (load_type)
            LD_B, LD_BU: acc_be = 4'b0001 << off;
            LD_H, LD_HU: begin
               acc_be     = off[1] ? 4'b1100 : 4'b0011;
               misaligned = off[0];
            end
            default: misaligned = (off != 2'b00);
         endcase
      end else begin
         case (store_type)
            ST_B: begin
               acc_be    = 4'b0001 << off;
               acc_wdata = {4{store_data[7:0]}};
            end
            ST_H: begin
               acc_be     = off[1] ? 4'b1100 : 4'b0011;
               acc_wdata  = {2{store_data[15:0]}};
               misaligned = off[0];
            end
            default: begin
               acc_wdata  = store_data;
               misaligned = (off != 2'b00);
            end
         endcase
      end
   end

   // The pipeline is frozen for the whole transaction except the cycle the ack lands in.
   always_comb begin
      if (state == IDLE) mem_stall = is_mem & ~misaligned;
      else               mem_stall = ~bus_ack;
   end

   // Load formatting works from the lane offset captured when the request was issued.
   always_comb begin
      case (lat_off)
         2'b00:   ld_byte = bus_rdata[7:0];
         2'b01:   ld_byte = bus_rdata[15:8];
         2'b10:   ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (lat_load_type)
         LD_B:    load_result = {{24{ld_byte[7]}}, ld_byte};
         LD_BU:   load_result = {24'h0, ld_byte};
         LD_H:    load_result = {{16{ld_half[15]}}, ld_half};
         LD_HU:   load_result = {16'h0, ld_half};
         default: load_result = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bus_req       <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= 32'h0;
         bus_be        <= 4'h0;
         bus_wdata     <= 32'h0;
         wb_wr_en      <= 1'b0;
         wb_wr_addr    <= 5'd0;
         wb_wr_data    <= 32'h0;
         misalign_err  <= 1'b0;
         lat_load_type <= LD_W;
         lat_off       <= 2'b00;
         lat_rd        <= 5'd0;
         lat_wb        <= 1'b0;
      end else begin
         wb_wr_en     <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (is_mem) begin
                  if (misaligned) begin
                     misalign_err <= 1'b1;
                  end else begin
                     state         <= WAIT;
                     bus_req       <= 1'b1;
                     bus_we        <= is_store;
                     bus_addr      <= {alu_result[31:2], 2'b00};
                     bus_be        <= acc_be;
                     bus_wdata     <= acc_wdata;
                     lat_load_type <= load_type;
                     lat_off       <= off;
                     lat_rd        <= rd;
                     lat_wb        <= wb_reg_file;
                  end
               end else if (mem_valid) begin
                  wb_wr_en   <= wb_reg_file & (rd != 5'd0);
                  wb_wr_addr <= rd;
                  wb_wr_data <= alu_result;
               end
            end
            WAIT: begin
               if (bus_ack) begin
                  state   <= IDLE;
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     wb_wr_en   <= lat_wb & (lat_rd != 5'd0);
                     wb_wr_addr <= lat_rd;
                     wb_wr_data <= load_result;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, ALU passthrough, loads, stores,
// misalignment and back-to-back traffic, each with hand-computed expectations.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_store_type;
   logic        wb_reg_file;
   logic [4:0]  rd;
   logic        mem_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        wb_wr_en;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .alu_result(alu_result),
      .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
      .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
      .wb_reg_file(wb_reg_file), .rd(rd), .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      mem_valid      = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      alu_result     = 32'h0;
      store_data     = 32'h0;
      mem_load_type  = 3'b010;
      mem_store_type = 2'b10;
      wb_reg_file    = 1'b0;
      rd             = 5'd0;
   endtask

   task automatic test_reset;
      logic [139:0] outs;
      rst = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
      idle_inputs();
      tick();
      tick();
      outs = {bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_wr_en, wb_wr_addr, wb_wr_data, misalign_err};
      checks++;
      if (outs !== 140'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h, expected 0", outs);
      end
      rst = 1'b1;
      tick();
      // Start a load and abandon it with reset while the request is outstanding.
      mem_valid = 1'b1; mem_read = 1'b1; mem_load_type = 3'b010;
      alu_result = 32'h100; rd = 5'd9; wb_reg_file = 1'b1;
      tick();
      checks++;
      if (bus_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_wait_entry: got bus_req=%b, expected 1", bus_req);
      end
      tick();
      #2 rst = 1'b0;
      #1;
      outs = {bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_wr_en, wb_wr_addr, wb_wr_data, misalign_err};
      checks++;
      if (outs !== 140'h0) begin
         errors++;
         $display("[TB] FAIL reset_async_clear: got %h, expected 0", outs);
      end
      idle_inputs();
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_state: got mem_stall=%b, expected 0", mem_stall);
      end
      tick();
      rst = 1'b1;
      bus_ack = 1'b1;
      bus_rdata = 32'hCAFEF00D;
      tick();
      bus_ack = 1'b0;
      checks++;
      if ({wb_wr_en, bus_req} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_late_ack: got wb_wr_en,bus_req=%b, expected 00", {wb_wr_en, bus_req});
      end
      tick();
      checks++;
      if (wb_wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_late_ack_2: got wb_wr_en=%b, expected 0", wb_wr_en);
      end
   endtask

   task automatic test_alu;
      mem_valid = 1'b1; rd = 5'd5; alu_result = 32'h1234; wb_reg_file = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alu_stall: got %b, expected 0", mem_stall);
      end
      tick();
      checks++;
      if ({wb_wr_en, wb_wr_addr, wb_wr_data} !== {1'b1, 5'd5, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL alu_wb: got en=%b addr=%0d data=%h, expected en=1 addr=5 data=00001234",
                  wb_wr_en, wb_wr_addr, wb_wr_data);
      end
      rd = 5'd0; alu_result = 32'h5678;
      tick();
      checks++;
      if (wb_wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alu_rd0: got wb_wr_en=%b, expected 0", wb_wr_en);
      end
      idle_inputs();
      tick();
   endtask

   // Load at 0x102 with two wait states before the ack.
   task automatic test_load(input logic [2:0] lt, input logic [3:0] exp_be,
                            input logic [31:0] exp_data, input string name);
      int stalls;
      stalls = 0;
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_load_type = lt;
      alu_result = 32'h102; rd = 5'd7; wb_reg_file = 1'b1;
      bus_rdata = 32'h80FF7F01;
      for (int c = 0; c < 4; c++) begin
         bus_ack = (c == 3);
         #1;
         if (mem_stall === 1'b1) stalls++;
         if (c > 0) begin
            checks++;
            if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b0, 32'h100, exp_be, 32'h0}) begin
               errors++;
               $display("[TB] FAIL %s_bus_c%0d: got req=%b we=%b addr=%h be=%b wdata=%h, expected req=1 we=0 addr=00000100 be=%b wdata=0",
                        name, c, bus_req, bus_we, bus_addr, bus_be, bus_wdata, exp_be);
            end
         end
         @(posedge clk);
         #1;
      end
      bus_ack = 1'b0;
      idle_inputs();
      checks++;
      if ({wb_wr_en, wb_wr_addr, wb_wr_data, bus_req} !== {1'b1, 5'd7, exp_data, 1'b0}) begin
         errors++;
         $display("[TB] FAIL %s_wb: got en=%b addr=%0d data=%h req=%b, expected en=1 addr=7 data=%h req=0",
                  name, wb_wr_en, wb_wr_addr, wb_wr_data, bus_req, exp_data);
      end
      checks++;
      if (stalls !== 3) begin
         errors++;
         $display("[TB] FAIL %s_stall_cycles: got %0d, expected 3", name, stalls);
      end
      tick();
      checks++;
      if (wb_wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_wb_single: got wb_wr_en=%b, expected 0", name, wb_wr_en);
      end
   endtask

   task automatic test_store(input logic [1:0] st, input logic [31:0] addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input string name);
      mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_store_type = st;
      alu_result = addr; store_data = 32'hAABBCCDD; rd = 5'd4; wb_reg_file = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_stall_issue: got %b, expected 1", name, mem_stall);
      end
      tick();
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, {addr[31:2], 2'b00}, exp_be, exp_wdata}) begin
         errors++;
         $display("[TB] FAIL %s_bus: got req=%b we=%b addr=%h be=%b wdata=%h, expected req=1 we=1 addr=%h be=%b wdata=%h",
                  name, bus_req, bus_we, bus_addr, bus_be, bus_wdata, {addr[31:2], 2'b00}, exp_be, exp_wdata);
      end
      bus_ack = 1'b1;
      #1;
      checks++;
      if ({mem_stall, wb_wr_en} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL %s_ack_cycle: got stall,wb_en=%b, expected 00", name, {mem_stall, wb_wr_en});
      end
      tick();
      bus_ack = 1'b0;
      idle_inputs();
      checks++;
      if ({wb_wr_en, bus_req} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL %s_no_wb: got wb_en,req=%b, expected 00", name, {wb_wr_en, bus_req});
      end
      tick();
   endtask

   task automatic test_misalign(input logic is_store, input logic [2:0] lt, input logic [1:0] st,
                                input logic [31:0] addr, input string name);
      mem_valid = 1'b1; mem_read = ~is_store; mem_write = is_store;
      mem_load_type = lt; mem_store_type = st; alu_result = addr;
      store_data = 32'h12345678; rd = 5'd6; wb_reg_file = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_stall: got %b, expected 0", name, mem_stall);
      end
      tick();
      idle_inputs();
      checks++;
      if ({misalign_err, bus_req, wb_wr_en} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL %s_pulse: got err,req,wb=%b, expected 100", name, {misalign_err, bus_req, wb_wr_en});
      end
      tick();
      checks++;
      if ({misalign_err, bus_req, wb_wr_en} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL %s_after: got err,req,wb=%b, expected 000", name, {misalign_err, bus_req, wb_wr_en});
      end
   endtask

   // Read and write both set, with an unknown load code: must behave as an LW.
   task automatic test_read_write_both;
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_load_type = 3'b111;
      mem_store_type = 2'b00; alu_result = 32'h400; store_data = 32'h99999999;
      rd = 5'd12; wb_reg_file = 1'b1; bus_rdata = 32'hDEADBEEF;
      tick();
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b0, 32'h400, 4'b1111, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rw_both_bus: got req=%b we=%b addr=%h be=%b wdata=%h, expected req=1 we=0 addr=00000400 be=1111 wdata=0",
                  bus_req, bus_we, bus_addr, bus_be, bus_wdata);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      idle_inputs();
      checks++;
      if ({wb_wr_en, wb_wr_addr, wb_wr_data} !== {1'b1, 5'd12, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL rw_both_wb: got en=%b addr=%0d data=%h, expected en=1 addr=12 data=deadbeef",
                  wb_wr_en, wb_wr_addr, wb_wr_data);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      bus_ack = 1'b1;
      bus_rdata = 32'h11223344;
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_load_type = 3'b010;
      alu_result = 32'h300; rd = 5'd3; wb_reg_file = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_load_issue_stall: got %b, expected 1", mem_stall);
      end
      tick();
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h300, 4'b1111}) begin
         errors++;
         $display("[TB] FAIL b2b_load_bus: got req=%b we=%b addr=%h be=%b, expected req=1 we=0 addr=00000300 be=1111",
                  bus_req, bus_we, bus_addr, bus_be);
      end
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_load_ack_stall: got %b, expected 0", mem_stall);
      end
      tick();
      mem_read = 1'b0; mem_write = 1'b1; mem_store_type = 2'b10;
      alu_result = 32'h304; store_data = 32'h55667788; rd = 5'd0; wb_reg_file = 1'b0;
      checks++;
      if ({wb_wr_en, wb_wr_addr, wb_wr_data, bus_req} !== {1'b1, 5'd3, 32'h11223344, 1'b0}) begin
         errors++;
         $display("[TB] FAIL b2b_load_wb: got en=%b addr=%0d data=%h req=%b, expected en=1 addr=3 data=11223344 req=0",
                  wb_wr_en, wb_wr_addr, wb_wr_data, bus_req);
      end
      #1;
      checks++;
      if (mem_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_store_issue_stall: got %b, expected 1", mem_stall);
      end
      tick();
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_wr_en} !== {1'b1, 1'b1, 32'h304, 4'b1111, 32'h55667788, 1'b0}) begin
         errors++;
         $display("[TB] FAIL b2b_store_bus: got req=%b we=%b addr=%h be=%b wdata=%h wb=%b, expected req=1 we=1 addr=00000304 be=1111 wdata=55667788 wb=0",
                  bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_wr_en);
      end
      tick();
      mem_write = 1'b0; alu_result = 32'hABC; rd = 5'd8; wb_reg_file = 1'b1;
      checks++;
      if ({bus_req, wb_wr_en} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL b2b_store_done: got req,wb=%b, expected 00", {bus_req, wb_wr_en});
      end
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_alu_stall: got %b, expected 0", mem_stall);
      end
      tick();
      checks++;
      if ({wb_wr_en, wb_wr_addr, wb_wr_data} !== {1'b1, 5'd8, 32'hABC}) begin
         errors++;
         $display("[TB] FAIL b2b_alu_wb: got en=%b addr=%0d data=%h, expected en=1 addr=8 data=00000abc",
                  wb_wr_en, wb_wr_addr, wb_wr_data);
      end
      bus_ack = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      $display("[TB] starting mem_access_unit bench");
      test_reset();
      test_alu();
      test_load(3'b000, 4'b0100, 32'hFFFFFFFF, "lb");
      test_load(3'b011, 4'b0100, 32'h000000FF, "lbu");
      test_load(3'b001, 4'b1100, 32'hFFFF80FF, "lh");
      test_load(3'b100, 4'b1100, 32'h000080FF, "lhu");
      test_store(2'b00, 32'h203, 4'b1000, 32'hDDDDDDDD, "sb");
      test_store(2'b01, 32'h202, 4'b1100, 32'hCCDDCCDD, "sh");
      test_store(2'b10, 32'h200, 4'b1111, 32'hAABBCCDD, "sw");
      test_misalign(1'b0, 3'b010, 2'b10, 32'h101, "mis_lw");
      test_misalign(1'b1, 3'b010, 2'b01, 32'h103, "mis_sh");
      test_read_write_both();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
